// File: rtl/ibex_pkg.sv
// Shared types for the instruction-side memory responder.
// Response bundle and LFSR seed used by the grant-stall option.
package ibex_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } instr_resp_t;

  localparam logic [15:0] INSTR_RESP_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/ibex_instr_resp_delay.sv
// Fixed-latency shift register for instruction responses.
// Idle stages carry an all-zero bundle so data/err read 0 without valid.
module ibex_instr_resp_delay
  import ibex_pkg::*;
#(
  parameter int Latency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  instr_resp_t resp_i,
  output instr_resp_t resp_o
);

  instr_resp_t pipe_q [Latency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Latency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= resp_i;
      for (int i = 1; i < Latency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign resp_o = pipe_q[Latency-1];

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Instruction memory behind the fetch req/gnt/rvalid bus.
// Define IBEX_INSTR_RESP_GNT_STALL_EN for LFSR-driven random grant denial.
module ibex_instr_mem_responder
  import ibex_pkg::*;
#(
  parameter logic [31:0] MemBase        = 32'h0000_0000,
  parameter int          MemDepthWords  = 1024,
  parameter int          RespLatency    = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        stall_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic        busy_o
);

  localparam int AW = $clog2(MemDepthWords);
  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);
  localparam logic [CW-1:0] One    = CW'(1);

  logic [31:0]   mem_q [MemDepthWords];
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic          rd_ok;
  logic          wr_ok;
  logic          lfsr_stall;
  logic [CW-1:0] cnt_q;
  instr_resp_t   resp_d;
  instr_resp_t   resp_q;

  assign rd_word = (instr_addr_i - MemBase) >> 2;
  assign wr_word = (wr_addr_i - MemBase) >> 2;
  assign rd_ok   = (instr_addr_i >= MemBase) &&
                   (rd_word < 32'(MemDepthWords));
  assign wr_ok   = (wr_addr_i >= MemBase) &&
                   (wr_word < 32'(MemDepthWords));

`ifdef IBEX_INSTR_RESP_GNT_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= INSTR_RESP_LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0],
                 lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign lfsr_stall = (lfsr_q[1:0] == 2'b00);
`else
  assign lfsr_stall = 1'b0;
`endif

  assign instr_gnt_o = instr_req_i & ~stall_i &
                       (cnt_q < MaxCnt) & ~lfsr_stall;

  // Combinational read before the edge gives read-before-write ordering
  always_comb begin
    resp_d       = '0;
    resp_d.valid = instr_gnt_o;
    resp_d.err   = instr_gnt_o & ~rd_ok;
    if (instr_gnt_o && rd_ok) begin
      resp_d.rdata = mem_q[rd_word[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_ok) begin
      mem_q[wr_word[AW-1:0]] <= wr_data_i;
    end
  end

  ibex_instr_resp_delay #(
    .Latency (RespLatency)
  ) u_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .resp_i (resp_d),
    .resp_o (resp_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (instr_gnt_o && !resp_q.valid) begin
      cnt_q <= cnt_q + One;
    end else if (!instr_gnt_o && resp_q.valid) begin
      cnt_q <= cnt_q - One;
    end
  end

  assign instr_rvalid_o = resp_q.valid;
  assign instr_rdata_o  = resp_q.rdata;
  assign instr_err_o    = resp_q.err;
  assign busy_o         = (cnt_q != '0);

endmodule
